// File: rtl/super_pkg.sv
// Shared types for the LSU responder: request/response bundles, data_type
// encodings, tracker entry layout and the byte-lane helper functions.
package super_pkg;

    localparam int unsigned MEM_TAG = 64;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic        rf_we;
        logic        is_cap;
        logic [2:0]  data_type;
        logic [64:0] wdata;
        logic        cheri_err;
        logic        align_err_only;
        logic [4:0]  cheri_cause;
        logic [4:0]  rf_waddr;
    } lsu_req_info_t;

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [4:0]  rf_waddr;
        logic [64:0] rdata;
        logic        err;
        logic [4:0]  cheri_cause;
    } lsu_resp_t;

    typedef struct packed {
        logic       is_load;
        logic       is_cap;
        logic [1:0] offset;
        logic [2:0] dtype;
        logic [4:0] rf_waddr;
        logic       local_err;
        logic [4:0] cause;
    } trk_entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BEAT1 = 1'b1
    } lsu_state_e;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            DT_BYTE: mask = 4'b0001;
            DT_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask << offset;
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            DT_BYTE: return {4{wdata[7:0]}};
            DT_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // dtype[2] set selects zero-extension, clear selects sign-extension.
    function automatic logic [31:0] load_fmt(input logic [31:0] rdata, input logic [1:0] offset,
                                             input logic [2:0] dtype);
        logic [31:0] shifted;
        logic        sx;
        shifted = rdata >> {offset, 3'b000};
        case (dtype[1:0])
            DT_BYTE: begin
                sx = ~dtype[2] & shifted[7];
                return {{24{sx}}, shifted[7:0]};
            end
            DT_HALF: begin
                sx = ~dtype[2] & shifted[15];
                return {{16{sx}}, shifted[15:0]};
            end
            default: return shifted;
        endcase
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// Outstanding-transaction tracker: small FIFO with a combinational head so
// the response path can answer in the rvalid cycle.
module lsu_resp_fifo
    import super_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_push,
    input  trk_entry_t i_entry,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output trk_entry_t o_head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    trk_entry_t      r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    // Explicit wrap so non-power-of-two depths stay modulo Depth.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/lsu_resp.sv
// LSU responder: issues requests on the data bus (one or two beats), tracks
// outstanding transactions and returns formatted load data in order.
module lsu_resp
    import super_pkg::*;
#(
    parameter logic        CHERIoTEn      = 1'b1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          lsu_req_i,
    input  lsu_req_info_t lsu_req_info_i,
    output logic          lsu_req_done_o,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [31:0]   data_addr_o,
    output logic [32:0]   data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [32:0]   data_rdata_i,
    input  logic          data_err_i,
    output logic          resp_valid_o,
    output logic          resp_is_load_o,
    output logic [4:0]    resp_rf_waddr_o,
    output logic [64:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic [4:0]    resp_cheri_cause_o,
    output logic          busy_o
);

    lsu_state_e r_state, w_state_next;
    logic       w_full, w_empty, w_push, w_pop, w_beat1, w_stage_beat, w_is_cap;
    logic       w_cap_err;
    trk_entry_t w_push_entry, w_head;
    lsu_resp_t  w_rsp;

    logic        r_stage_valid;
    logic [31:0] r_stage_lo;
    logic        r_stage_tag;
    logic        r_stage_err;

    assign w_is_cap = CHERIoTEn & lsu_req_info_i.is_cap;

    always_comb begin
        w_state_next   = r_state;
        lsu_req_done_o = 1'b0;
        data_req_o     = 1'b0;
        w_push         = 1'b0;
        w_beat1        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Faulted requests need a tracker slot too, so they also wait on full.
                if (lsu_req_i && lsu_req_info_i.cheri_err && !w_full) begin
                    lsu_req_done_o = 1'b1;
                    w_push         = 1'b1;
                end else if (lsu_req_i && !lsu_req_info_i.cheri_err && !w_full) begin
                    data_req_o = 1'b1;
                    if (data_gnt_i) begin
                        if (w_is_cap) begin
                            w_state_next = S_BEAT1;
                        end else begin
                            lsu_req_done_o = 1'b1;
                            w_push         = 1'b1;
                        end
                    end
                end
            end
            S_BEAT1: begin
                data_req_o = 1'b1;
                w_beat1    = 1'b1;
                if (data_gnt_i) begin
                    lsu_req_done_o = 1'b1;
                    w_push         = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign data_we_o   = data_req_o & ~lsu_req_info_i.rf_we;
    assign data_addr_o = data_req_o ? ({lsu_req_info_i.addr[31:2], 2'b00} + (w_beat1 ? 32'd4 : 32'd0))
                                    : 32'd0;
    assign data_be_o   = !data_req_o ? 4'h0 :
                         w_is_cap    ? 4'hF :
                         be_gen(lsu_req_info_i.data_type[1:0], lsu_req_info_i.addr[1:0]);
    assign data_wdata_o = !data_req_o ? 33'd0 :
                          w_is_cap    ? {lsu_req_info_i.wdata[MEM_TAG],
                                         w_beat1 ? lsu_req_info_i.wdata[63:32] : lsu_req_info_i.wdata[31:0]} :
                          {1'b0, wdata_rep(lsu_req_info_i.data_type[1:0], lsu_req_info_i.wdata[31:0])};

    always_comb begin
        w_push_entry.is_load   = lsu_req_info_i.rf_we;
        w_push_entry.is_cap    = w_is_cap;
        w_push_entry.offset    = lsu_req_info_i.addr[1:0];
        w_push_entry.dtype     = lsu_req_info_i.data_type;
        w_push_entry.rf_waddr  = lsu_req_info_i.rf_waddr;
        w_push_entry.local_err = lsu_req_info_i.cheri_err;
        // Pure alignment faults are not capability violations and report cause 0.
        w_push_entry.cause     = (lsu_req_info_i.cheri_err && !lsu_req_info_i.align_err_only)
                                 ? lsu_req_info_i.cheri_cause : 5'd0;
    end

    lsu_resp_fifo #(.Depth(MaxOutstanding)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_rsp        = '0;
        w_pop        = 1'b0;
        w_stage_beat = 1'b0;
        w_cap_err    = r_stage_err | data_err_i;
        if (!w_empty) begin
            if (w_head.local_err) begin
                w_rsp.valid       = 1'b1;
                w_rsp.is_load     = w_head.is_load;
                w_rsp.rf_waddr    = w_head.rf_waddr;
                w_rsp.err         = 1'b1;
                w_rsp.cheri_cause = w_head.cause;
                w_pop             = 1'b1;
            end else if (data_rvalid_i) begin
                if (w_head.is_cap && !r_stage_valid) begin
                    w_stage_beat = 1'b1;
                end else begin
                    w_rsp.valid    = 1'b1;
                    w_rsp.is_load  = w_head.is_load;
                    w_rsp.rf_waddr = w_head.rf_waddr;
                    w_pop          = 1'b1;
                    if (w_head.is_cap) begin
                        w_rsp.err = w_cap_err;
                        if (w_head.is_load)
                            w_rsp.rdata = {r_stage_tag & data_rdata_i[32] & ~w_cap_err,
                                           data_rdata_i[31:0], r_stage_lo};
                    end else begin
                        w_rsp.err = data_err_i;
                        if (w_head.is_load)
                            w_rsp.rdata = {33'd0, load_fmt(data_rdata_i[31:0], w_head.offset, w_head.dtype)};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_stage_valid <= 1'b0;
            r_stage_lo    <= '0;
            r_stage_tag   <= 1'b0;
            r_stage_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_stage_beat) begin
                r_stage_valid <= 1'b1;
                r_stage_lo    <= data_rdata_i[31:0];
                r_stage_tag   <= data_rdata_i[32];
                r_stage_err   <= data_err_i;
            end else if (w_pop) begin
                r_stage_valid <= 1'b0;
            end
        end
    end

    assign resp_valid_o       = w_rsp.valid;
    assign resp_is_load_o     = w_rsp.is_load;
    assign resp_rf_waddr_o    = w_rsp.rf_waddr;
    assign resp_rdata_o       = w_rsp.rdata;
    assign resp_err_o         = w_rsp.err;
    assign resp_cheri_cause_o = w_rsp.cheri_cause;
    assign busy_o             = ~w_empty | (r_state == S_BEAT1);

    a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> !w_empty);
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu_req_i && !lsu_req_done_o) |=> (lsu_req_i && $stable(lsu_req_info_i)));

endmodule

// File: tb/tb_lsu_resp.sv
// Directed bench for lsu_resp: bus-side checks inline, responses checked by
// a negedge monitor against an in-order queue of expected results.
module tb_lsu_resp;
    import super_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          lsu_req_i;
    lsu_req_info_t lsu_req_info_i;
    logic          lsu_req_done_o;
    logic          data_req_o, data_gnt_i, data_we_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_addr_o;
    logic [32:0]   data_wdata_o;
    logic          data_rvalid_i;
    logic [32:0]   data_rdata_i;
    logic          data_err_i;
    logic          resp_valid_o, resp_is_load_o, resp_err_o, busy_o;
    logic [4:0]    resp_rf_waddr_o, resp_cheri_cause_o;
    logic [64:0]   resp_rdata_o;

    always #5 clk_i = ~clk_i;

    lsu_resp #(.CHERIoTEn(1'b1), .MaxOutstanding(2)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .lsu_req_i          (lsu_req_i),
        .lsu_req_info_i     (lsu_req_info_i),
        .lsu_req_done_o     (lsu_req_done_o),
        .data_req_o         (data_req_o),
        .data_gnt_i         (data_gnt_i),
        .data_we_o          (data_we_o),
        .data_be_o          (data_be_o),
        .data_addr_o        (data_addr_o),
        .data_wdata_o       (data_wdata_o),
        .data_rvalid_i      (data_rvalid_i),
        .data_rdata_i       (data_rdata_i),
        .data_err_i         (data_err_i),
        .resp_valid_o       (resp_valid_o),
        .resp_is_load_o     (resp_is_load_o),
        .resp_rf_waddr_o    (resp_rf_waddr_o),
        .resp_rdata_o       (resp_rdata_o),
        .resp_err_o         (resp_err_o),
        .resp_cheri_cause_o (resp_cheri_cause_o),
        .busy_o             (busy_o)
    );

    typedef struct packed {
        logic        is_load;
        logic [4:0]  waddr;
        logic [64:0] rdata;
        logic        err;
        logic [4:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic rf_we, input logic is_cap,
                           input logic [2:0] dt, input logic [64:0] wdata, input logic cheri_err,
                           input logic [4:0] cause, input logic [4:0] waddr);
        lsu_req_info_i.addr           = addr;
        lsu_req_info_i.rf_we          = rf_we;
        lsu_req_info_i.is_cap         = is_cap;
        lsu_req_info_i.data_type      = dt;
        lsu_req_info_i.wdata          = wdata;
        lsu_req_info_i.cheri_err      = cheri_err;
        lsu_req_info_i.align_err_only = 1'b0;
        lsu_req_info_i.cheri_cause    = cause;
        lsu_req_info_i.rf_waddr       = waddr;
        lsu_req_i = 1'b1;
    endtask

    // Response monitor: every presented response must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_o) begin
            exp_t a, e;
            a = '{resp_is_load_o, resp_rf_waddr_o, resp_rdata_o, resp_err_o, resp_cheri_cause_o};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got %0h, expected no response", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL resp: got %0h, expected %0h", a, e);
                end else begin
                    $display("resp ok: waddr=%0d rdata=%0h err=%0b cause=%0h", a.waddr, a.rdata, a.err, a.cause);
                end
            end
        end
    end

    initial begin
        lsu_req_i = 0; lsu_req_info_i = '0; data_gnt_i = 0;
        data_rvalid_i = 0; data_rdata_i = '0; data_err_i = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_bus", {data_req_o, data_we_o, data_be_o, data_addr_o}, '0);
        chk("rst_wdata", data_wdata_o, '0);
        chk("rst_resp", {resp_valid_o, resp_is_load_o, resp_rf_waddr_o, resp_err_o,
                         resp_cheri_cause_o, busy_o, lsu_req_done_o}, '0);
        chk("rst_rdata", resp_rdata_o, '0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // 1: word load
        set_req(32'h1004, 1, 0, 3'b010, '0, 0, 5'd0, 5'd1); data_gnt_i = 1;
        exp_q.push_back('{1'b1, 5'd1, 65'h0_DEADBEEF, 1'b0, 5'd0});
        @(negedge clk_i);
        chk("t1_done", lsu_req_done_o, 1); chk("t1_addr", data_addr_o, 32'h1004);
        chk("t1_be", data_be_o, 4'hF);     chk("t1_we", data_we_o, 0);
        cyc(); lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_DEADBEEF;
        @(negedge clk_i); chk("t1_resp_valid", resp_valid_o, 1);
        cyc(); data_rvalid_i = 0;

        // 2: signed byte load
        set_req(32'h1003, 1, 0, 3'b000, '0, 0, 5'd0, 5'd2); data_gnt_i = 1;
        exp_q.push_back('{1'b1, 5'd2, 65'h0_FFFFFF80, 1'b0, 5'd0});
        @(negedge clk_i); chk("t2_be", data_be_o, 4'b1000); chk("t2_addr", data_addr_o, 32'h1000);
        cyc(); lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_80000000;
        cyc(); data_rvalid_i = 0;

        // 3: capability store, grant after two waits per beat
        set_req(32'h2000, 0, 1, 3'b010, {1'b1, 32'hCAFEF00D, 32'h12345678}, 0, 5'd0, 5'd0);
        exp_q.push_back('{1'b0, 5'd0, 65'd0, 1'b0, 5'd0});
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                data_gnt_i = (k == 2);
                @(negedge clk_i);
                chk($sformatf("t3_addr_b%0d_k%0d", b, k), data_addr_o, 32'h2000 + 32'(4 * b));
                chk($sformatf("t3_wdata_b%0d_k%0d", b, k), data_wdata_o,
                    (b == 1) ? 33'h1_CAFEF00D : 33'h1_12345678);
                chk($sformatf("t3_done_b%0d_k%0d", b, k), lsu_req_done_o, (b == 1 && k == 2));
                cyc();
            end
        end
        lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = '0;
        cyc(); cyc(); data_rvalid_i = 0;

        // 4: CHERI fault behind an outstanding load
        set_req(32'h3000, 1, 0, 3'b010, '0, 0, 5'd0, 5'd4); data_gnt_i = 1;
        exp_q.push_back('{1'b1, 5'd4, 65'h0_11223344, 1'b0, 5'd0});
        @(negedge clk_i); chk("t4_load_done", lsu_req_done_o, 1);
        cyc(); data_gnt_i = 0;
        set_req(32'h0, 1, 0, 3'b010, '0, 1, 5'h02, 5'd5);
        exp_q.push_back('{1'b1, 5'd5, 65'd0, 1'b1, 5'h02});
        @(negedge clk_i);
        chk("t4_err_done", lsu_req_done_o, 1); chk("t4_err_noreq", data_req_o, 0);
        cyc(); lsu_req_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_11223344;
        cyc(); data_rvalid_i = 0;
        cyc();

        // 5: tracker full holds the third request
        data_gnt_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_req(32'h4000 + 32'(4 * i), 1, 0, 3'b010, '0, 0, 5'd0, 5'(6 + i));
            exp_q.push_back('{1'b1, 5'(6 + i), 65'(32'hA0 + i), 1'b0, 5'd0});
            @(negedge clk_i);
            chk($sformatf("t5_done_%0d", i), lsu_req_done_o, (i < 2));
            if (i == 2) chk("t5_req_held", data_req_o, 0);
            if (i < 2) cyc();
        end
        cyc(); data_rvalid_i = 1; data_rdata_i = 33'h0_000000A0;
        @(negedge clk_i); chk("t5_req_held_rv", data_req_o, 0);
        cyc(); data_rvalid_i = 0;
        @(negedge clk_i); chk("t5_req_release", data_req_o, 1); chk("t5_done_2b", lsu_req_done_o, 1);
        cyc(); lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_000000A1;
        cyc(); data_rdata_i = 33'h0_000000A2;
        cyc(); data_rvalid_i = 0;

        // 6: capability load, bus error on beat 1; 7: clean capability load
        for (int t = 0; t < 2; t++) begin
            set_req(32'h5000, 1, 1, 3'b010, '0, 0, 5'd0, 5'(9 + t)); data_gnt_i = 1;
            exp_q.push_back('{1'b1, 5'(9 + t), {(t == 1), 32'h22222222, 32'h11111111}, (t == 0), 5'd0});
            @(negedge clk_i); chk($sformatf("t%0d_beat0_done", 6 + t), lsu_req_done_o, 0);
            cyc();
            @(negedge clk_i); chk($sformatf("t%0d_beat1_addr", 6 + t), data_addr_o, 32'h5004);
            chk($sformatf("t%0d_beat1_done", 6 + t), lsu_req_done_o, 1);
            cyc(); lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h1_11111111;
            @(negedge clk_i); chk($sformatf("t%0d_beat0_quiet", 6 + t), resp_valid_o, 0);
            cyc(); data_rdata_i = 33'h1_22222222; data_err_i = (t == 0);
            cyc(); data_rvalid_i = 0; data_err_i = 0;
        end

        // 8: unsigned halfword load from the upper half
        set_req(32'h6002, 1, 0, 3'b101, '0, 0, 5'd0, 5'd12); data_gnt_i = 1;
        exp_q.push_back('{1'b1, 5'd12, 65'h0_00008001, 1'b0, 5'd0});
        @(negedge clk_i); chk("t8_be", data_be_o, 4'b1100);
        cyc(); lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_80010000;
        cyc(); data_rvalid_i = 0;

        repeat (3) cyc();
        chk("drain", 65'(exp_q.size()), 65'd0);
        chk("busy_end", busy_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
